// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// vga_pkg : shared VGA timing presets and helpers
// Rev 1.0 : initial release
// ============================================================================
package vga_pkg;

    // 640x480@60, 25.175 MHz pixel clock
    localparam int c_VGA640_H_ACTIVE = 640;
    localparam int c_VGA640_H_FP     = 16;
    localparam int c_VGA640_H_SYNC   = 96;
    localparam int c_VGA640_H_BP     = 48;
    localparam int c_VGA640_V_ACTIVE = 480;
    localparam int c_VGA640_V_FP     = 10;
    localparam int c_VGA640_V_SYNC   = 2;
    localparam int c_VGA640_V_BP     = 33;

    // 800x600@72, 50 MHz pixel clock
    localparam int c_SVGA72_H_ACTIVE = 800;
    localparam int c_SVGA72_H_FP     = 56;
    localparam int c_SVGA72_H_SYNC   = 120;
    localparam int c_SVGA72_H_BP     = 64;
    localparam int c_SVGA72_V_ACTIVE = 600;
    localparam int c_SVGA72_V_FP     = 37;
    localparam int c_SVGA72_V_SYNC   = 6;
    localparam int c_SVGA72_V_BP     = 23;

    function automatic int f_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_tick_div.sv
`default_nettype none
// ============================================================================
// vga_tick_div : clk -> pixel strobe divider, one tick every CLK_DIV clocks
// Rev 1.0 : initial release
// ============================================================================
module vga_tick_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int c_DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_DW-1:0] c_LAST = c_DW'(CLK_DIV - 1);

    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_clk_div
        $error("vga_tick_div: CLK_DIV must be in 1..16");
    end

    logic [c_DW-1:0] div_q;
    logic [c_DW-1:0] div_d;
    logic            w_last;

    assign w_last = (div_q == c_LAST);
    // Gated by reset so no strobe escapes while the block is held cleared.
    assign tick   = reset & en & w_last;

    always_comb begin
        div_d = div_q;
        if (en) begin
            div_d = w_last ? '0 : div_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// vga_timing_gen : pixel/line counters, sync/blank decode and frame counter
// Rev 1.0 : initial release
// ============================================================================
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = c_VGA640_H_ACTIVE,
    parameter int   H_FP     = c_VGA640_H_FP,
    parameter int   H_SYNC   = c_VGA640_H_SYNC,
    parameter int   H_BP     = c_VGA640_H_BP,
    parameter int   V_ACTIVE = c_VGA640_V_ACTIVE,
    parameter int   V_FP     = c_VGA640_V_FP,
    parameter int   V_SYNC   = c_VGA640_V_SYNC,
    parameter int   V_BP     = c_VGA640_V_BP,
    parameter int   CLK_DIV  = 4,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   CW       = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    output logic          tick,
    output logic [CW-1:0] pixelx,
    output logic [CW-1:0] pixely,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic          line_end,
    output logic          frame_end,
    output logic [7:0]    frame_cnt
);

    localparam int c_H_TOT = f_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int c_V_TOT = f_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam longint c_CNT_RANGE = longint'(1) << CW;

    if (c_CNT_RANGE < longint'(c_H_TOT) || c_CNT_RANGE < longint'(c_V_TOT)) begin : g_bad_cw
        $error("vga_timing_gen: CW too narrow for the line or frame total");
    end

    localparam logic [CW-1:0] c_H_LAST = CW'(c_H_TOT - 1);
    localparam logic [CW-1:0] c_V_LAST = CW'(c_V_TOT - 1);
    // Decode bounds carry one extra bit so an end bound equal to 2^CW still compares correctly.
    localparam logic [CW:0]   c_H_ACT  = (CW+1)'(H_ACTIVE);
    localparam logic [CW:0]   c_HS_BEG = (CW+1)'(H_ACTIVE + H_FP);
    localparam logic [CW:0]   c_HS_END = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW:0]   c_V_ACT  = (CW+1)'(V_ACTIVE);
    localparam logic [CW:0]   c_VS_BEG = (CW+1)'(V_ACTIVE + V_FP);
    localparam logic [CW:0]   c_VS_END = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

    logic [CW-1:0] pixelx_q, pixelx_d;
    logic [CW-1:0] pixely_q, pixely_d;
    logic [7:0]    frame_cnt_q, frame_cnt_d;
    logic          w_tick, w_h_last, w_v_last, w_line_end, w_frame_end;
    logic [CW:0]   w_px_ext, w_py_ext;

    vga_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_div (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .tick  (w_tick)
    );

    assign w_h_last    = (pixelx_q == c_H_LAST);
    assign w_v_last    = (pixely_q == c_V_LAST);
    assign w_line_end  = w_tick & w_h_last;
    assign w_frame_end = w_line_end & w_v_last;

    always_comb begin
        pixelx_d    = pixelx_q;
        pixely_d    = pixely_q;
        frame_cnt_d = frame_cnt_q;
        if (w_tick) begin
            pixelx_d = w_h_last ? '0 : pixelx_q + 1'b1;
            if (w_h_last) begin
                pixely_d = w_v_last ? '0 : pixely_q + 1'b1;
            end
        end
        if (w_frame_end) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pixelx_q    <= '0;
            pixely_q    <= '0;
            frame_cnt_q <= '0;
        end else begin
            pixelx_q    <= pixelx_d;
            pixely_q    <= pixely_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Sync and blank decode straight off the counters: no pipeline offset.
    assign w_px_ext  = {1'b0, pixelx_q};
    assign w_py_ext  = {1'b0, pixely_q};
    assign hsync     = (w_px_ext >= c_HS_BEG && w_px_ext < c_HS_END) ? HS_POL : ~HS_POL;
    assign vsync     = (w_py_ext >= c_VS_BEG && w_py_ext < c_VS_END) ? VS_POL : ~VS_POL;
    assign video_on  = (w_px_ext < c_H_ACT) && (w_py_ext < c_V_ACT);

    assign tick      = w_tick;
    assign pixelx    = pixelx_q;
    assign pixely    = pixely_q;
    assign line_end  = w_line_end;
    assign frame_end = w_frame_end;
    assign frame_cnt = frame_cnt_q;

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: hsync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vsync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- CLK_DIV, 4: clk cycles per pixel; legal values 1..16.
- HS_POL, 0: hsync active level.
- VS_POL, 0: vsync active level.
- CW, 10: width of the pixel and line counters.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: the single clock. All logic is on its rising edge.
- reset, in, 1: synchronous, active-low reset.
- en, in, 1: run enable. When 0, the divider and counters freeze.
- tick, out, 1: one-clk pixel strobe.
- pixelx, out, CW: horizontal counter.
- pixely, out, CW: vertical counter.
- hsync, out, 1: horizontal sync.
- vsync, out, 1: vertical sync.
- video_on, out, 1: high inside the visible area.
- line_end, out, 1: one-clk pulse on the last tick of a line.
- frame_end, out, 1: one-clk pulse on the last tick of a frame.
- frame_cnt, out, 8: frame counter; wraps modulo 256.

Function
REQ-003 The totals SHALL be H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOT = V_ACTIVE+V_FP+V_SYNC+V_BP. Elaboration SHALL fail if 2^CW < max(H_TOT, V_TOT) or if CLK_DIV < 1.
REQ-004 The divider SHALL count 0..CLK_DIV-1 while en=1. tick SHALL be 1 in the clk cycle where the divider equals CLK_DIV-1. With CLK_DIV=1, tick SHALL equal en.
REQ-005 On each clk with tick=1, pixelx SHALL increment. At H_TOT-1 it SHALL wrap to 0.
REQ-006 On a tick where pixelx=H_TOT-1, pixely SHALL increment. At V_TOT-1 it SHALL wrap to 0.
REQ-007 hsync SHALL equal HS_POL while H_ACTIVE+H_FP <= pixelx < H_ACTIVE+H_FP+H_SYNC, and ~HS_POL otherwise.
REQ-008 vsync SHALL equal VS_POL while V_ACTIVE+V_FP <= pixely < V_ACTIVE+V_FP+V_SYNC, and ~VS_POL otherwise.
REQ-009 video_on SHALL be 1 exactly when pixelx < H_ACTIVE and pixely < V_ACTIVE.
REQ-010 hsync, vsync and video_on SHALL be decoded from the current counter values with zero added latency, with no clk offset relative to pixelx/pixely.
REQ-011 line_end SHALL be (tick and pixelx=H_TOT-1).
REQ-012 frame_end SHALL be (line_end and pixely=V_TOT-1).
REQ-013 frame_cnt SHALL increment on the clk after frame_end; 255 wraps to 0.
REQ-014 When en=0, the divider, counters and frame_cnt SHALL hold. tick, line_end and frame_end SHALL be 0. Sync outputs SHALL reflect the held counters.
REQ-015 When en returns to 1, counting SHALL resume from the held divider value, with no extra tick.

Reset
REQ-016 When reset=0 at a clk edge, the following SHALL be cleared to 0 regardless of en: divider, pixelx, pixely, frame_cnt, tick, line_end and frame_end.
REQ-017 While reset is held low, the outputs SHALL be: hsync=~HS_POL, vsync=~VS_POL, video_on=1 (pixel 0,0 is visible).
REQ-018 A reset asserted mid-frame SHALL abort the frame: no frame_end pulse and no frame_cnt increment. After release, the first tick SHALL occur CLK_DIV clks later.

Structure
REQ-019 A shared package vga_pkg SHALL hold the default 640x480 timing constants. It SHALL also hold one additional preset, 800x600@72 (H 800/56/120/64, V 600/37/6/23).
REQ-020 The generic divider SHALL be one sub-module, vga_tick_div, with parameter CLK_DIV and ports clk, reset, en, tick. The two counters and all decode logic SHALL live in vga_timing_gen.

Verification
REQ-021 Default parameters, en=1, run one full frame:
- tick period is exactly 4 clk.
- frame_end occurs 1,680,000 clk after reset release.
- frame_cnt goes 0 -> 1.
REQ-022 Default line check:
- hsync=0 for pixelx 656..751 (96 ticks), 1 elsewhere.
- vsync=0 only for pixely 490..491.
- video_on count per frame = 307,200 ticks.
REQ-023 Reset mid-frame: assert reset=0 for 1 clk at pixelx=300, pixely=200.
- Next cycle: pixelx=0, pixely=0, frame_cnt=0, no frame_end.
- The next frame_end occurs 1,680,000 clk later.
REQ-024 Enable pause: drop en for 37 clk at pixelx=639.
- No tick during the pause.
- pixelx stays 639 for 37 clk plus the normal tick interval, then goes to 640.
- The frame length is extended by exactly 37 clk.
REQ-025 Small geometry: H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V 2/1/1/1, CLK_DIV=1, HS_POL=1, VS_POL=1.
- tick is constantly 1.
- hsync=1 at pixelx 5..6.
- vsync=1 at pixely 3.
- frame_end every 40 clk.
- frame_cnt wraps 255 -> 0 after 256 frames.
